// File: rtl/pipeline_sequencer_pkg.sv
// Shared definitions for the RV32I pipeline sequencer: FSM encoding, forwarding
// select codes and the per-stage shadow payloads.
package pipeline_sequencer_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MEMWAIT = 1'b1;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             load;
    logic             store;
  } stage_t;

  // WB never issues a memory access, so it carries no access flags
  typedef struct packed {
    logic             v;
    logic [REG_W-1:0] rd;
    logic             regwrite;
  } wb_t;

  // A valid writer of a non-zero rd that matches the given source register
  function automatic logic rd_match(input logic v, input logic regwrite,
                                    input logic [REG_W-1:0] rd,
                                    input logic [REG_W-1:0] rs);
    return v & regwrite & (rd == rs) & (rd != '0);
  endfunction

endpackage

// File: rtl/pipeline_sequencer_hazard_fwd_unit.sv
// Combinational load-use detection for the instruction in ID and EX operand
// forwarding selects from the MEM/WB shadows.
module hazard_fwd_unit
  import pipeline_sequencer_pkg::*;
(
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic             ex_v,
  input  logic             ex_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] ex_rs1,
  input  logic [REG_W-1:0] ex_rs2,
  input  logic             mem_v,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] mem_rd,
  input  wb_t              wb,
  output logic             load_use,
  output logic [1:0]       fwd1sel,
  output logic [1:0]       fwd2sel
);

  logic id_src_hit;

  assign id_src_hit = (id_rs1_used & (id_rs1 == ex_rd)) |
                      (id_rs2_used & (id_rs2 == ex_rd));
  assign load_use   = ex_v & ex_load & (ex_rd != '0) & id_src_hit;

  // MEM result is younger than WB data, so it wins when both match
  always_comb begin
    fwd1sel = FWD_REG;
    fwd2sel = FWD_REG;
    if (rd_match(mem_v, mem_regwrite, mem_rd, ex_rs1))     fwd1sel = FWD_MEM;
    else if (rd_match(wb.v, wb.regwrite, wb.rd, ex_rs1))   fwd1sel = FWD_WB;
    if (rd_match(mem_v, mem_regwrite, mem_rd, ex_rs2))     fwd2sel = FWD_MEM;
    else if (rd_match(wb.v, wb.regwrite, wb.rd, ex_rs2))   fwd2sel = FWD_WB;
  end

endmodule

// File: rtl/pipeline_sequencer.sv
// Five-stage RV32I pipeline sequencer: stage shadows, stall/bubble/flush control,
// MEM-stage req/ack handshake with timeout, and stall-cycle counter.
module pipeline_sequencer
  import pipeline_sequencer_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_regwrite,
  input  logic             id_load,
  input  logic             id_store,
  input  logic             ex_redirect,
  input  logic             mem_ack,
  output logic             pc_en,
  output logic             ir1_en,
  output logic             adv,
  output logic             flush_id,
  output logic             bubble_ex,
  output logic [1:0]       fwd1sel,
  output logic [1:0]       fwd2sel,
  output logic             mem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned TO_W = $clog2(MEM_TIMEOUT + 1);

  logic [0:0]       state, state_nxt;
  logic [TO_W-1:0]  cnt, cnt_nxt;
  stage_t           ex_q, mem_q;
  wb_t              wb_q;
  logic [REG_W-1:0] ex_rs1_q, ex_rs2_q;
  logic             load_use, mem_access, mem_busy, timeout, go, err_set;

  hazard_fwd_unit u_hazard_fwd (
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_v         (ex_q.v),
    .ex_load      (ex_q.load),
    .ex_rd        (ex_q.rd),
    .ex_rs1       (ex_rs1_q),
    .ex_rs2       (ex_rs2_q),
    .mem_v        (mem_q.v),
    .mem_regwrite (mem_q.regwrite),
    .mem_rd       (mem_q.rd),
    .wb           (wb_q),
    .load_use     (load_use),
    .fwd1sel      (fwd1sel),
    .fwd2sel      (fwd2sel)
  );

  assign mem_access = mem_q.v & (mem_q.load | mem_q.store);
  assign mem_busy   = mem_access & ~mem_ack;
  assign timeout    = (cnt == TO_W'(MEM_TIMEOUT - 1));

  // go: the pipeline advances this cycle; hazards are only resolved when it does
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    go        = 1'b0;
    err_set   = 1'b0;
    mem_req   = 1'b0;
    pc_en     = 1'b1;
    ir1_en    = 1'b1;
    adv       = 1'b1;
    flush_id  = 1'b0;
    bubble_ex = 1'b0;
    case (state)
      ST_RUN: begin
        mem_req = mem_access;
        if (mem_busy) begin
          state_nxt = ST_MEMWAIT;
          cnt_nxt   = '0;
        end else begin
          go = 1'b1;
        end
      end
      ST_MEMWAIT: begin
        mem_req = 1'b1;
        if (mem_ack || timeout) begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
          go        = 1'b1;
          err_set   = ~mem_ack;
        end else begin
          cnt_nxt = cnt + TO_W'(1);
        end
      end
      default: state_nxt = ST_RUN;
    endcase

    if (!go) begin
      pc_en  = 1'b0;
      ir1_en = 1'b0;
      adv    = 1'b0;
    end else if (ex_q.v && ex_redirect) begin
      flush_id  = 1'b1;
      bubble_ex = 1'b1;
    end else if (load_use) begin
      pc_en     = 1'b0;
      ir1_en    = 1'b0;
      bubble_ex = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_RUN;
      cnt          <= '0;
      mem_err      <= 1'b0;
      stall_cycles <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (err_set) mem_err <= 1'b1;
      if (!adv || !pc_en) stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  // Stage shadows; unused source fields are zeroed so they never forward
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q     <= '0;
      ex_rs1_q <= '0;
      ex_rs2_q <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
    end else if (adv) begin
      if (bubble_ex) begin
        ex_q     <= '0;
        ex_rs1_q <= '0;
        ex_rs2_q <= '0;
      end else begin
        ex_q     <= '{v: 1'b1, rd: id_rd, regwrite: id_regwrite,
                      load: id_load, store: id_store};
        ex_rs1_q <= id_rs1_used ? id_rs1 : '0;
        ex_rs2_q <= id_rs2_used ? id_rs2 : '0;
      end
      mem_q <= ex_q;
      wb_q  <= '{v: mem_q.v, rd: mem_q.rd, regwrite: mem_q.regwrite};
    end
  end

endmodule
